tb_doutb_map: RTL
=================

Name: tb_doutb_map

Overview:
- Read-side counterpart of the temp-buffer port-B write mapper.
- Takes the L-lane temp-buffer port-B read word (TB_doutb), selects and orders X lanes by direction, and drives the systolic-array edge input.
- Applies the diagonal skew the array requires: lane i is delayed i cycles beyond lane 0.
- Reports in-flight status and end-of-burst to the array controller.

Parameters:
- X, 4, systolic-array edge width in lanes; must satisfy X <= L.
- Y, 4, array depth; carried for interface symmetry, unused in logic.
- L, 4, temp-buffer lane count.
- RSA_DW, 16, lane data width in bits.
- CNT_W, 16, width of the row counter.

Ports:
- clk  input  1  system clock.
- sys_rst  input  1  asynchronous, active-high reset.
- TB_doutb_sel  input  2  direction: DIR_IDLE=00, DIR_POS=01, DIR_NEG=10, DIR_NEW=11.
- TB_doutb  input  L*RSA_DW  temp-buffer port-B read data.
- RSA_din  output  X*RSA_DW  skewed data to the array edge; lane i is bits [i*RSA_DW +: RSA_DW].
- RSA_din_vld  output  X  per-lane valid, aligned with RSA_din lanes.
- busy  output  1  high while any valid is in flight.
- done  output  1  one-cycle pulse on the busy 1->0 transition.
- row_cnt  output  CNT_W  number of rows accepted since reset or since the last done.

Behaviour:
- Reset is asynchronous, active-high. On assertion all registers clear immediately:
  - RSA_din=0, RSA_din_vld=0, busy=0, done=0, row_cnt=0, all pipeline data and valids.
- Reset mid-burst discards every in-flight row. No done pulse is issued for the aborted burst.

Stage 1 (map register), every clk:
- DIR_POS: s1 lane i <= TB_doutb lane i; s1_vld <= 1.
- DIR_NEG: s1 lane i <= TB_doutb lane X-1-i; s1_vld <= 1.
- DIR_IDLE, DIR_NEW: s1_vld <= 0; s1 data holds its previous value.
- Lanes X..L-1 of TB_doutb are ignored.

Stage 2 (skew), triangular shift register:
- Lane i passes through i extra registers, i.e. i+1 registers total from stage 1.
- Each valid bit travels alongside its data.
- Latency from TB_doutb to RSA_din lane i is i+1 cycles, so lane 0 appears the cycle after the sample edge.
- The pipeline shifts every cycle; there is no stall input.

busy = OR of s1_vld and every skew-pipe valid bit, registered.
- For a single-cycle burst it stays high for X cycles.

done:
- Pulses for 1 cycle on the cycle after busy falls.
- Never asserted in the same cycle as busy.

row_cnt:
- Increments by 1 on each cycle s1_vld is loaded with 1.
- Saturates at 2^CNT_W-1.
- Clears to 0 on the cycle after done. If a new row is accepted in that same cycle, row_cnt becomes 1.

Back-to-back bursts with no idle gap: busy stays high and no done pulse occurs.

Optional Feature:
- Macro: TB_DOUTB_ZERO_GATE_EN.
- Defined: any RSA_din lane whose RSA_din_vld bit is 0 is driven as 0; stage-1 data also loads 0 in DIR_IDLE/DIR_NEW.
- Undefined: invalid lanes carry stale shifted data; consumers must qualify with RSA_din_vld.

Decomposition:
- Shared package: DIR_IDLE/DIR_POS/DIR_NEG/DIR_NEW constants, also used by the write-side mapper, plus a RSA_DW default constant.
- Natural sub-module: skew_delay_line, a parameterized depth-D, width-W register chain with a valid bit. Instantiate it X times with D=i.

Test Plan (X=L=4, RSA_DW=16):
- Reset: assert sys_rst mid-clock, no edge -> all outputs 0 immediately; after release with IDLE input, outputs stay 0.
- POS single row, TB_doutb lanes {0x0003,0x0002,0x0001,0x0000} (lane3..lane0), sel=POS for one cycle:
  - lane0=0x0000 valid at +1, lane1=0x0001 at +2, lane2=0x0002 at +3, lane3=0x0003 at +4.
  - busy high for 4 cycles; done pulses at +5; row_cnt=1 before done, 0 after.
- NEG single row, same data -> lane0=0x0003 at +1, lane1=0x0002 at +2, lane2=0x0001 at +3, lane3=0x0000 at +4.
- Burst of 3 POS rows back-to-back -> row_cnt=3; busy continuous for 6 cycles; exactly one done pulse.
- sel=NEW with data 0xFFFF on all lanes -> RSA_din_vld stays 0, busy stays 0, row_cnt unchanged.
  - With TB_DOUTB_ZERO_GATE_EN, RSA_din stays 0.
- Reset asserted 2 cycles into a 4-row burst -> outputs cleared at once, no done pulse, row_cnt=0.

Source files
------------

// File: rtl/tb_doutb_map_pkg.sv
// Shared definitions for the temp-buffer port-B mappers (read and write side).
//
// Contents:
//   dir_e       - lane-ordering direction carried on TB_doutb_sel / TB_dinb_sel
//   RSA_DW_DEF  - default lane data width in bits
//   src_lane()  - which temp-buffer lane feeds array-edge lane i for a direction
package tb_doutb_map_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_NEW  = 2'b11
  } dir_e;

  localparam int RSA_DW_DEF = 16;

  // Forward direction keeps lane order; reverse direction mirrors it across
  // the X edge lanes (lanes beyond X are never referenced).
  function automatic int src_lane(input int i, input int x, input logic neg);
    return neg ? (x - 1 - i) : i;
  endfunction

endpackage

// File: rtl/tb_doutb_map_skew_delay_line.sv
// skew_delay_line: depth-D, width-W register chain with a valid bit that
// travels alongside the data.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   in_data   in   W-bit data entering the chain
//   in_vld    in   valid qualifying in_data
//   out_data  out  in_data delayed by D cycles (D=0: combinational pass-through)
//   out_vld   out  in_vld delayed by D cycles
//   pend_nxt  out  OR of the valid bits the chain will hold after the next
//                  edge; lets the parent register an exact busy flag
module skew_delay_line
  import tb_doutb_map_pkg::*;
#(
  parameter int D = 1,
  parameter int W = RSA_DW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  output logic         pend_nxt
);

  generate
    if (D == 0) begin : g_thru
      // Lane 0 has no extra delay; the clock and reset are not needed here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign out_data = in_data;
      assign out_vld  = in_vld;
      assign pend_nxt = 1'b0;
    end else begin : g_chain
      logic [W-1:0] data_q [D];
      logic [D-1:0] vld_q;
      logic [D-1:0] vld_nxt;

      // Next-state view of the valid chain, shared by the register and pend_nxt.
      always_comb begin
        vld_nxt[0] = in_vld;
        for (int k = 1; k < D; k++) begin
          vld_nxt[k] = vld_q[k-1];
        end
      end

      // NOTE: the data chain is reset too, so a mid-burst reset leaves no
      // stale row that could reappear on the array edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) begin
            data_q[k] <= '0;
          end
          vld_q <= '0;
        end else begin
          data_q[0] <= in_data;
          for (int k = 1; k < D; k++) begin
            data_q[k] <= data_q[k-1];
          end
          vld_q <= vld_nxt;
        end
      end

      assign out_data = data_q[D-1];
      assign out_vld  = vld_q[D-1];
      assign pend_nxt = |vld_nxt;
    end
  endgenerate

endmodule

// File: rtl/tb_doutb_map.sv
// tb_doutb_map: read-side temp-buffer port-B mapper feeding the systolic-array
// edge. Selects and orders X of the L temp-buffer lanes by direction, applies
// the diagonal skew (lane i lags lane 0 by i cycles), and reports busy / done /
// row count to the array controller.
//
// Ports:
//   clk           in   system clock
//   sys_rst       in   asynchronous, active-high reset
//   TB_doutb_sel  in   direction (dir_e): IDLE / POS / NEG / NEW
//   TB_doutb      in   L*RSA_DW temp-buffer port-B read word
//   RSA_din       out  X*RSA_DW skewed edge data, lane i at [i*RSA_DW +: RSA_DW]
//   RSA_din_vld   out  X per-lane valid bits
//   busy          out  high while any row is in flight
//   done          out  one-cycle pulse on the busy 1->0 transition
//   row_cnt       out  rows accepted since reset or the last done (saturating)
//
// Build option: TB_DOUTB_ZERO_GATE_EN - when defined, invalid edge lanes are
// driven as 0 and stage 1 loads 0 on IDLE/NEW; otherwise invalid lanes carry
// stale data and must be qualified with RSA_din_vld.
module tb_doutb_map
  import tb_doutb_map_pkg::*;
#(
  parameter int X      = 4,
  parameter int Y      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = RSA_DW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic [1:0]          TB_doutb_sel,
  input  logic [L*RSA_DW-1:0] TB_doutb,
  output logic [X*RSA_DW-1:0] RSA_din,
  output logic [X-1:0]        RSA_din_vld,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    row_cnt
);

  // Array depth is part of the shared interface but does not affect this side.
  localparam int UNUSED_Y = Y;

  // Only lanes 0..X-1 are mapped; the rest of the read word is ignored.
  logic unused_doutb;
  assign unused_doutb = ^TB_doutb;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Stage 1: direction map register
  // ---------------------------------------------------------------------------
  logic [X*RSA_DW-1:0] s1_data, s1_data_nxt;
  logic                s1_vld,  s1_vld_nxt;
  dir_e                dir;

  assign dir = dir_e'(TB_doutb_sel);

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    s1_data_nxt = s1_data;
    s1_vld_nxt  = 1'b0;
    case (dir)
      DIR_POS, DIR_NEG: begin
        s1_vld_nxt = 1'b1;
        for (int i = 0; i < X; i++) begin
          s1_data_nxt[i*RSA_DW +: RSA_DW] =
            TB_doutb[src_lane(i, X, dir == DIR_NEG)*RSA_DW +: RSA_DW];
        end
      end
      default: begin
`ifdef TB_DOUTB_ZERO_GATE_EN
        s1_data_nxt = '0;
`else
        s1_data_nxt = s1_data;
`endif
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_data <= s1_data_nxt;
      s1_vld  <= s1_vld_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: triangular skew, lane i delayed i further cycles
  // ---------------------------------------------------------------------------
  logic [X*RSA_DW-1:0] skew_data;
  logic [X-1:0]        skew_vld;
  logic [X-1:0]        pend_nxt;

  generate
    for (genvar i = 0; i < X; i++) begin : g_lane
      skew_delay_line #(
        .D (i),
        .W (RSA_DW)
      ) u_skew (
        .clk      (clk),
        .rst      (sys_rst),
        .in_data  (s1_data[i*RSA_DW +: RSA_DW]),
        .in_vld   (s1_vld),
        .out_data (skew_data[i*RSA_DW +: RSA_DW]),
        .out_vld  (skew_vld[i]),
        .pend_nxt (pend_nxt[i])
      );

`ifdef TB_DOUTB_ZERO_GATE_EN
      assign RSA_din[i*RSA_DW +: RSA_DW] =
        skew_vld[i] ? skew_data[i*RSA_DW +: RSA_DW] : '0;
`else
      assign RSA_din[i*RSA_DW +: RSA_DW] = skew_data[i*RSA_DW +: RSA_DW];
`endif
    end
  endgenerate

  assign RSA_din_vld = skew_vld;

  // ---------------------------------------------------------------------------
  // Status: busy / done / row_cnt
  // ---------------------------------------------------------------------------
  // busy is registered from the next-state of every valid bit in the pipe, so
  // it is high exactly while some valid bit is held: X cycles for one row.
  logic busy_nxt;
  assign busy_nxt = s1_vld_nxt | (|pend_nxt);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      row_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      // Falling edge of busy; done is therefore never high together with busy.
      done <= busy & ~busy_nxt;
      // The cycle after done restarts the count, still counting a row
      // accepted on that same edge.
      if (done) begin
        row_cnt <= s1_vld_nxt ? CNT_W'(1) : '0;
      end else if (s1_vld_nxt && row_cnt != CNT_MAX) begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

endmodule
